// File: rtl/dibr_frame_writer_if.sv
// Pixel-stream handshake and SRAM write-control bundle for dibr_frame_writer.
// master: the side that supplies pixels and frame start/finish strobes.
// slave : the frame writer itself.
// The SRAM data bus is bidirectional, so it stays a plain inout on the writer.
//   i_frame_start   start one frame
//   i_pix_valid     pixel word valid
//   i_pix_data      pixel word
//   o_pix_ready     writer accepts the pixel this cycle
//   o_sram_addr     SRAM address
//   o_sram_we_n     SRAM write enable, active low
//   o_sram_oe_n     SRAM output enable, held inactive
//   o_proc_finish   one-cycle pulse when the frame is fully written
//   i_frame_finish  reader has consumed the frame
//   o_busy          writer is not idle
interface dibr_frame_writer_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic              i_frame_start;
   logic              i_pix_valid;
   logic [DATA_W-1:0] i_pix_data;
   logic              o_pix_ready;
   logic [ADDR_W-1:0] o_sram_addr;
   logic              o_sram_we_n;
   logic              o_sram_oe_n;
   logic              o_proc_finish;
   logic              i_frame_finish;
   logic              o_busy;

   modport master (
      output i_frame_start, i_pix_valid, i_pix_data, i_frame_finish,
      input  o_pix_ready, o_sram_addr, o_sram_we_n, o_sram_oe_n, o_proc_finish, o_busy
   );

   modport slave (
      input  i_frame_start, i_pix_valid, i_pix_data, i_frame_finish,
      output o_pix_ready, o_sram_addr, o_sram_we_n, o_sram_oe_n, o_proc_finish, o_busy
   );
endinterface

// File: rtl/dibr_frame_writer.sv
// Write side of the DIBR frame-buffer SRAM protocol.
// Accepts pixel words over a valid/ready handshake and writes one frame of
// FRAME_WORDS words to consecutive SRAM addresses starting at BASE_ADDR
// (address wraps modulo 2^ADDR_W). After the last word it pulses
// o_proc_finish to kick the frame reader, then waits for i_frame_finish.
// Ports:
//   clk           system clock, all logic on posedge
//   rst           asynchronous, active-high reset
//   bus           handshake / SRAM control bundle (slave modport)
//   io_sram_data  SRAM data bus, driven only while o_sram_we_n is low
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for i_frame_start
// S_ACCEPT  | o_pix_ready high, waiting for a pixel handshake
// S_STROBE  | o_sram_we_n low for one cycle, captured word on the bus
// S_DONE    | o_proc_finish pulse, counters rewound to BASE_ADDR
// S_WAIT_RD | holding off until the reader returns i_frame_finish
module dibr_frame_writer #(
   parameter int                ADDR_W      = 20,
   parameter int                DATA_W      = 16,
   parameter int                FRAME_WORDS = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   dibr_frame_writer_if.slave     bus,
   inout  wire  [DATA_W-1:0]      io_sram_data
);

   localparam int               CNT_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_STROBE,
      S_DONE,
      S_WAIT_RD
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;

   logic              pix_ready;
   logic              we_n;
   logic              proc_finish;
   logic              busy;
   logic              wdata_load;
   logic              cnt_clr;
   logic              cnt_inc;

   // Strobes decode from the registered state only; inputs only steer the
   // next state and the datapath enables.
   always_comb begin
      state_nxt   = state;
      pix_ready   = 1'b0;
      we_n        = 1'b1;
      proc_finish = 1'b0;
      busy        = 1'b1;
      wdata_load  = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;

      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (bus.i_frame_start) begin
               cnt_clr   = 1'b1;
               state_nxt = S_ACCEPT;
            end
         end

         S_ACCEPT: begin
            pix_ready = 1'b1;
            if (bus.i_pix_valid) begin
               wdata_load = 1'b1;
               state_nxt  = S_STROBE;
            end
         end

         S_STROBE: begin
            we_n = 1'b0;
            if (count == LAST_CNT) begin
               state_nxt = S_DONE;
            end else begin
               cnt_inc   = 1'b1;
               state_nxt = S_ACCEPT;
            end
         end

         S_DONE: begin
            proc_finish = 1'b1;
            cnt_clr     = 1'b1;
            state_nxt   = S_WAIT_RD;
         end

         S_WAIT_RD: begin
            // A simultaneous i_frame_start is dropped: a new frame needs a
            // fresh start request seen in S_IDLE.
            if (bus.i_frame_finish) begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // addr tracks BASE_ADDR + count incrementally so the adder is only one bit
   // wide in spirit; its natural ADDR_W overflow gives the modulo wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         addr  <= BASE_ADDR;
         wdata <= '0;
      end else begin
         if (cnt_clr) begin
            count <= '0;
            addr  <= BASE_ADDR;
         end else if (cnt_inc) begin
            count <= count + CNT_W'(1);
            addr  <= addr + ADDR_W'(1);
         end
         if (wdata_load) begin
            wdata <= bus.i_pix_data;
         end
      end
   end

   assign bus.o_pix_ready   = pix_ready;
   assign bus.o_sram_we_n   = we_n;
   assign bus.o_sram_oe_n   = 1'b1;
   assign bus.o_proc_finish = proc_finish;
   assign bus.o_busy        = busy;
   assign bus.o_sram_addr   = addr;

   // Released as soon as the state leaves S_STROBE, including on async reset.
   assign io_sram_data = we_n ? {DATA_W{1'bz}} : wdata;

endmodule

// File: tb/tb_dibr_frame_writer.sv
module tb_dibr_frame_writer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dibr_frame_writer_if #(.ADDR_W(20), .DATA_W(16)) ifa ();
   dibr_frame_writer_if #(.ADDR_W(20), .DATA_W(16)) ifb ();

   // Pulled-up data nets: an undriven bus reads back as all ones.
   tri1 [15:0] data_a;
   tri1 [15:0] data_b;

   dibr_frame_writer #(
      .ADDR_W(20), .DATA_W(16), .FRAME_WORDS(256), .BASE_ADDR(20'h00000)
   ) dut_a (
      .clk(clk), .rst(rst), .bus(ifa), .io_sram_data(data_a)
   );

   dibr_frame_writer #(
      .ADDR_W(20), .DATA_W(16), .FRAME_WORDS(32), .BASE_ADDR(20'hFFFF0)
   ) dut_b (
      .clk(clk), .rst(rst), .bus(ifb), .io_sram_data(data_b)
   );

   int tests = 0;
   int fails = 0;

   logic [15:0] mem_a [256];
   logic [15:0] mem_b [logic [19:0]];
   int          wr_cnt_a = 0;
   int          wr_cnt_b = 0;
   int          pf_cnt_a = 0;
   int          pf_cnt_b = 0;
   int          cyc = 0;
   int          last_we_cyc = 0;
   int          pf_cyc = 0;
   bit          strict = 1'b0;
   bit          in_wait = 1'b0;
   bit          hs_prev = 1'b0;
   logic [15:0] hs_data = '0;
   logic [19:0] last_wr_addr = '0;

   // Per-cycle bus/handshake monitor for dut_a, plus a write recorder for dut_b.
   always @(negedge clk) begin
      cyc++;
      tests++;
      if (ifa.o_sram_oe_n !== 1'b1 || ifb.o_sram_oe_n !== 1'b1) begin
         fails++;
         $display("FAIL oe_n t=%0t a=%b b=%b expected 1", $time, ifa.o_sram_oe_n, ifb.o_sram_oe_n);
      end
      if (ifa.o_sram_we_n === 1'b0) begin
         tests++;
         if (!hs_prev || data_a !== hs_data || ifa.o_sram_addr > 20'd255) begin
            fails++;
            $display("FAIL write_hs t=%0t hs_prev=%0b bus=%h expected %h addr=%h", $time, hs_prev, data_a, hs_data, ifa.o_sram_addr);
         end
         if (strict && wr_cnt_a > 0) begin
            tests++;
            if (cyc - last_we_cyc != 2) begin
               fails++;
               $display("FAIL we_spacing t=%0t got %0d expected 2", $time, cyc - last_we_cyc);
            end
         end
         mem_a[ifa.o_sram_addr[7:0]] = data_a;
         last_wr_addr = ifa.o_sram_addr;
         last_we_cyc  = cyc;
         wr_cnt_a++;
      end else begin
         tests++;
         if (data_a !== 16'hFFFF) begin
            fails++;
            $display("FAIL bus_z_a t=%0t bus=%h expected released (FFFF)", $time, data_a);
         end
      end
      if (ifa.o_proc_finish === 1'b1) begin
         pf_cnt_a++;
         pf_cyc  = cyc;
         in_wait = 1'b1;
      end
      if (ifa.o_busy === 1'b0) in_wait = 1'b0;
      tests++;
      if (ifa.o_pix_ready === 1'b1 && (ifa.o_sram_we_n !== 1'b1 || ifa.o_proc_finish !== 1'b0 || in_wait)) begin
         fails++;
         $display("FAIL ready_state t=%0t ready=1 we_n=%b pf=%b in_wait=%0b expected ready=0", $time, ifa.o_sram_we_n, ifa.o_proc_finish, in_wait);
      end
      hs_prev = (ifa.i_pix_valid === 1'b1) && (ifa.o_pix_ready === 1'b1) && !rst;
      hs_data = ifa.i_pix_data;

      if (ifb.o_sram_we_n === 1'b0) begin
         mem_b[ifb.o_sram_addr] = data_b;
         wr_cnt_b++;
      end else begin
         tests++;
         if (data_b !== 16'hFFFF) begin
            fails++;
            $display("FAIL bus_z_b t=%0t bus=%h expected released (FFFF)", $time, data_b);
         end
      end
      if (ifb.o_proc_finish === 1'b1) pf_cnt_b++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mem_a();
      for (int i = 0; i < 256; i++) mem_a[i] = '0;
   endtask

   task automatic start_a();
      ifa.i_frame_start = 1'b1;
      tick(1);
      ifa.i_frame_start = 1'b0;
   endtask

   task automatic send_a(input logic [15:0] d, input int gap);
      int  k;
      bit  done;
      for (int i = 0; i < gap; i++) begin
         ifa.i_pix_valid = 1'b0;
         tick(1);
      end
      ifa.i_pix_valid = 1'b1;
      ifa.i_pix_data  = d;
      k    = 0;
      done = 1'b0;
      while (!done && k < 20) begin
         done = (ifa.o_pix_ready === 1'b1);
         tick(1);
         k++;
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL send_a_timeout data=%h ready=%b expected 1 within 20 cycles", d, ifa.o_pix_ready);
      end
   endtask

   task automatic send_b(input logic [15:0] d);
      int  k;
      bit  done;
      ifb.i_pix_valid = 1'b1;
      ifb.i_pix_data  = d;
      k    = 0;
      done = 1'b0;
      while (!done && k < 20) begin
         done = (ifb.o_pix_ready === 1'b1);
         tick(1);
         k++;
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL send_b_timeout data=%h ready=%b expected 1 within 20 cycles", d, ifb.o_pix_ready);
      end
   endtask

   task automatic wait_pf_a(input int target);
      int k = 0;
      while (pf_cnt_a < target && k < 10) begin
         tick(1);
         k++;
      end
      tests++;
      if (pf_cnt_a < target) begin
         fails++;
         $display("FAIL pf_a_timeout pf_cnt=%0d expected %0d", pf_cnt_a, target);
      end
   endtask

   task automatic finish_a();
      ifa.i_frame_finish = 1'b1;
      tick(1);
      ifa.i_frame_finish = 1'b0;
   endtask

   task automatic check_frame_a(input string name);
      int bad = 0;
      for (int n = 0; n < 256; n++) begin
         if (mem_a[n] !== 16'(3 * n + 1)) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s_contents bad_words=%0d expected 0 (mem[1]=%h expected 0004)", name, bad, mem_a[1]);
      end
      tests++;
      if (wr_cnt_a != 256) begin
         fails++;
         $display("FAIL %s_write_count got %0d expected 256", name, wr_cnt_a);
      end
   endtask

   task automatic test_reset();
      ifa.i_frame_start = 0; ifa.i_pix_valid = 0; ifa.i_pix_data = 0; ifa.i_frame_finish = 0;
      ifb.i_frame_start = 0; ifb.i_pix_valid = 0; ifb.i_pix_data = 0; ifb.i_frame_finish = 0;
      rst = 1'b1;
      tick(3);
      tests++;
      if (ifa.o_pix_ready !== 1'b0 || ifa.o_sram_we_n !== 1'b1 || ifa.o_proc_finish !== 1'b0 || ifa.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl ready=%b we_n=%b pf=%b busy=%b expected 0 1 0 0", ifa.o_pix_ready, ifa.o_sram_we_n, ifa.o_proc_finish, ifa.o_busy);
      end
      tests++;
      if (ifa.o_sram_addr !== 20'h00000 || ifb.o_sram_addr !== 20'hFFFF0) begin
         fails++;
         $display("FAIL reset_addr a=%h b=%h expected 00000 FFFF0", ifa.o_sram_addr, ifb.o_sram_addr);
      end
      tests++;
      if (data_a !== 16'hFFFF || ifa.o_sram_oe_n !== 1'b1) begin
         fails++;
         $display("FAIL reset_bus bus=%h oe_n=%b expected FFFF 1", data_a, ifa.o_sram_oe_n);
      end
      // Inputs other than start are ignored in IDLE.
      ifa.i_pix_valid = 1'b1;
      ifa.i_frame_finish = 1'b1;
      rst = 1'b0;
      tick(3);
      tests++;
      if (ifa.o_busy !== 1'b0 || wr_cnt_a != 0) begin
         fails++;
         $display("FAIL idle_ignore busy=%b writes=%0d expected 0 0", ifa.o_busy, wr_cnt_a);
      end
      ifa.i_pix_valid = 1'b0;
      ifa.i_frame_finish = 1'b0;
   endtask

   task automatic test_stream_held();
      clear_mem_a();
      wr_cnt_a = 0;
      pf_cnt_a = 0;
      strict   = 1'b1;
      start_a();
      for (int n = 0; n < 256; n++) send_a(16'(3 * n + 1), 0);
      ifa.i_pix_valid = 1'b0;
      wait_pf_a(1);
      strict = 1'b0;
      check_frame_a("held");
      tests++;
      if (pf_cyc != last_we_cyc + 1) begin
         fails++;
         $display("FAIL pf_latency got %0d cycles after last write expected 1", pf_cyc - last_we_cyc);
      end
      tick(3);
      tests++;
      if (pf_cnt_a != 1 || ifa.o_busy !== 1'b1) begin
         fails++;
         $display("FAIL pf_single pf_cnt=%0d busy=%b expected 1 1", pf_cnt_a, ifa.o_busy);
      end
      finish_a();
      tests++;
      if (ifa.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL held_to_idle busy=%b expected 0", ifa.o_busy);
      end
   endtask

   task automatic test_stream_random();
      clear_mem_a();
      wr_cnt_a = 0;
      pf_cnt_a = 0;
      start_a();
      for (int n = 0; n < 256; n++) send_a(16'(3 * n + 1), int'($urandom_range(0, 2)));
      ifa.i_pix_valid = 1'b0;
      wait_pf_a(1);
      check_frame_a("random");
      finish_a();
      tests++;
      if (ifa.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL random_to_idle busy=%b expected 0", ifa.o_busy);
      end
   endtask

   task automatic test_wrap();
      int          bad = 0;
      logic [19:0] a;
      int          k = 0;
      wr_cnt_b = 0;
      pf_cnt_b = 0;
      ifb.i_frame_start = 1'b1;
      tick(1);
      ifb.i_frame_start = 1'b0;
      for (int n = 0; n < 32; n++) send_b(16'(3 * n + 1));
      ifb.i_pix_valid = 1'b0;
      while (pf_cnt_b < 1 && k < 10) begin
         tick(1);
         k++;
      end
      tests++;
      if (pf_cnt_b != 1) begin
         fails++;
         $display("FAIL wrap_pf pf_cnt=%0d expected 1", pf_cnt_b);
      end
      for (int n = 0; n < 32; n++) begin
         a = 20'hFFFF0 + 20'(n);
         if (!mem_b.exists(a)) bad++;
         else if (mem_b[a] !== 16'(3 * n + 1)) bad++;
      end
      tests++;
      if (bad != 0 || wr_cnt_b != 32 || mem_b.num() != 32) begin
         fails++;
         $display("FAIL wrap_contents bad=%0d writes=%0d entries=%0d expected 0 32 32", bad, wr_cnt_b, mem_b.num());
      end
      a = 20'h00000;
      tests++;
      if (!mem_b.exists(a) || mem_b[a] !== 16'd49) begin
         fails++;
         $display("FAIL wrap_first_low mem[00000] present=%0b expected word 16 = 0031", mem_b.exists(a));
      end
      ifb.i_frame_finish = 1'b1;
      tick(1);
      ifb.i_frame_finish = 1'b0;
      tests++;
      if (ifb.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL wrap_to_idle busy=%b expected 0", ifb.o_busy);
      end
   endtask

   task automatic test_wait_hold();
      int w0;
      int bad = 0;
      pf_cnt_a = 0;
      start_a();
      for (int n = 0; n < 256; n++) send_a(16'(3 * n + 1), 0);
      ifa.i_pix_valid = 1'b0;
      wait_pf_a(1);
      w0 = wr_cnt_a;
      ifa.i_frame_start = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (ifa.o_busy !== 1'b1 || ifa.o_pix_ready !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0 || wr_cnt_a != w0) begin
         fails++;
         $display("FAIL wait_hold bad_cycles=%0d extra_writes=%0d expected 0 0", bad, wr_cnt_a - w0);
      end
      ifa.i_frame_finish = 1'b1;
      tick(1);
      ifa.i_frame_start = 1'b0;
      ifa.i_frame_finish = 1'b0;
      tests++;
      if (ifa.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL wait_release busy=%b expected 0", ifa.o_busy);
      end
      tick(1);
      tests++;
      if (ifa.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL start_with_finish busy=%b expected 0 (start ignored)", ifa.o_busy);
      end
      start_a();
      send_a(16'h1234, 0);
      ifa.i_pix_valid = 1'b0;
      tick(1);
      tests++;
      if (last_wr_addr !== 20'h00000 || mem_a[0] !== 16'h1234) begin
         fails++;
         $display("FAIL restart_base addr=%h data=%h expected 00000 1234", last_wr_addr, mem_a[0]);
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_reset_mid();
      int pf0 = pf_cnt_a;
      start_a();
      for (int n = 0; n <= 100; n++) send_a(16'h0100 + 16'(n), 0);
      tests++;
      if (ifa.o_sram_we_n !== 1'b0 || ifa.o_sram_addr !== 20'd100) begin
         fails++;
         $display("FAIL word100_strobe we_n=%b addr=%h expected 0 00064", ifa.o_sram_we_n, ifa.o_sram_addr);
      end
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (ifa.o_sram_we_n !== 1'b1 || data_a !== 16'hFFFF || ifa.o_busy !== 1'b0 || ifa.o_sram_addr !== 20'h0) begin
         fails++;
         $display("FAIL async_release we_n=%b bus=%h busy=%b addr=%h expected 1 FFFF 0 00000", ifa.o_sram_we_n, data_a, ifa.o_busy, ifa.o_sram_addr);
      end
      ifa.i_pix_valid = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(3);
      tests++;
      if (pf_cnt_a != pf0) begin
         fails++;
         $display("FAIL reset_no_pf pf_cnt=%0d expected %0d", pf_cnt_a, pf0);
      end
      start_a();
      send_a(16'hBEEF, 0);
      ifa.i_pix_valid = 1'b0;
      tick(1);
      tests++;
      if (last_wr_addr !== 20'h00000 || mem_a[0] !== 16'hBEEF) begin
         fails++;
         $display("FAIL reset_restart addr=%h data=%h expected 00000 BEEF", last_wr_addr, mem_a[0]);
      end
   endtask

   task automatic test_early_finish();
      int pf0 = pf_cnt_a;
      ifa.i_frame_finish = 1'b1;
      tick(1);
      ifa.i_frame_finish = 1'b0;
      tests++;
      if (ifa.o_busy !== 1'b1 || ifa.o_pix_ready !== 1'b1) begin
         fails++;
         $display("FAIL finish_in_accept busy=%b ready=%b expected 1 1", ifa.o_busy, ifa.o_pix_ready);
      end
      for (int n = 1; n < 256; n++) send_a(16'h0200 + 16'(n), 0);
      ifa.i_pix_valid = 1'b0;
      wait_pf_a(pf0 + 1);
      tick(5);
      tests++;
      if (ifa.o_busy !== 1'b1) begin
         fails++;
         $display("FAIL early_finish_forgotten busy=%b expected 1", ifa.o_busy);
      end
      tests++;
      if (mem_a[0] !== 16'hBEEF || mem_a[255] !== 16'h02FF) begin
         fails++;
         $display("FAIL tail_frame mem0=%h mem255=%h expected BEEF 02FF", mem_a[0], mem_a[255]);
      end
      finish_a();
      tests++;
      if (ifa.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL tail_to_idle busy=%b expected 0", ifa.o_busy);
      end
   endtask

   initial begin
      test_reset();
      test_stream_held();
      test_stream_random();
      test_wrap();
      test_wait_hold();
      test_reset_mid();
      test_early_finish();
      tick(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
